// File: rtl/pingpong_nibble_buffer_pkg.sv
// ---------------------------------------------------------------------------
// pingpong_pkg
//   Shared definitions for the two-slot ping-pong nibble buffer.
//   - W_DEF     : default data width (one nibble)
//   - occ_e     : occupancy state of the buffer (EMPTY / ONE / FULL)
// ---------------------------------------------------------------------------
package pingpong_pkg;

    localparam int W_DEF = 4;

    // Occupancy count doubles as the state encoding.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pingpong_nibble_buffer_if.sv
// ---------------------------------------------------------------------------
// pingpong_nibble_buffer_if
//   Producer and consumer handshake bundle for the ping-pong nibble buffer.
//   Signals:
//     in_valid / in_ready / in_data     producer side
//     out_valid / out_ready / out_data  consumer side
//     sel                               mux select (1 = slot A, 0 = slot B)
//   Modports:
//     master : the environment (drives in_*, out_ready)
//     slave  : the buffer (drives in_ready, out_*, sel)
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid and ready are both 1. The consumer may hold valid or ready
//   low for any number of cycles; data is only meaningful while valid is 1.
// ---------------------------------------------------------------------------
interface pingpong_nibble_buffer_if
    import pingpong_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         sel;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sel
    );

endinterface

// File: rtl/pingpong_nibble_buffer_mux.sv
// ---------------------------------------------------------------------------
// nibble_sel_mux
//   W-bit 2:1 mux, s=1 selects a, s=0 selects b.
//   Ports: a, b (W) data in; s select; y (W) data out.
// ---------------------------------------------------------------------------
module nibble_sel_mux #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? a : b;

endmodule

// File: rtl/pingpong_nibble_buffer.sv
// ---------------------------------------------------------------------------
// pingpong_nibble_buffer
//   Two-slot ping-pong buffer in front of the quad 2:1 mux. Nibbles are
//   written alternately into slot A and slot B and read back in arrival
//   order by steering the mux select.
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     bus        pingpong_nibble_buffer_if.slave (in_*, out_*, sel)
//     state_dbg  current occupancy state (EMPTY / ONE / FULL)
//
//   Build option:
//     PINGPONG_FULL_THRU_EN  when defined, a FULL buffer also accepts a
//                            push in a cycle where it is being popped; the
//                            slot being read out is rewritten on the same
//                            edge and the buffer stays FULL.
//
//   All outputs derive from registers only; there is no combinational path
//   from in_* to out_*. With the build option, in_ready depends on
//   out_ready.
// ---------------------------------------------------------------------------
module pingpong_nibble_buffer
    import pingpong_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    pingpong_nibble_buffer_if.slave      bus,
    output occ_e                         state_dbg
);

    occ_e         state;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [W-1:0] slot_a;
    logic [W-1:0] slot_b;
    logic [W-1:0] mux_y;
    logic         push;
    logic         pop;

`ifdef PINGPONG_FULL_THRU_EN
    assign bus.in_ready = (state != ST_FULL) | bus.out_ready;
`else
    assign bus.in_ready = (state != ST_FULL);
`endif

    assign bus.out_valid = (state != ST_EMPTY);
    assign bus.sel       = ~rd_ptr;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    nibble_sel_mux #(.W(W)) u_mux (
        .a (slot_a),
        .b (slot_b),
        .s (bus.sel),
        .y (mux_y)
    );

    assign bus.out_data = mux_y;
    assign state_dbg    = state;

    // Occupancy state, pointers and slots. When FULL, wr_ptr equals rd_ptr,
    // so a pass-through push lands in the slot that is being popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            slot_a <= '0;
            slot_b <= '0;
        end else begin
            if (push) begin
                if (wr_ptr == 1'b0) begin
                    slot_a <= bus.in_data;
                end else begin
                    slot_b <= bus.in_data;
                end
                wr_ptr <= ~wr_ptr;
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                ST_EMPTY: begin
                    if (push) state <= ST_ONE;
                end
                ST_ONE: begin
                    if (push && !pop)      state <= ST_FULL;
                    else if (pop && !push) state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop && !push) state <= ST_ONE;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule
